regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter for the single register-file write port. It merges the in-order pipeline writeback (port A) with results from a long-latency unit such as mul/div or an uncached load (port B), and buffers B results in a small FIFO. It stalls the pipeline when a buffered result has waited too long. It sits between the writeback stage / long-latency unit and the register file's `we`/`wAddr`/`wData` inputs.

## Interface
Parameters:
- `DEPTH`, 2: B-result FIFO entries (power of two, 2..8).
- `STARVE_MAX`, 4: cycles a FIFO head may wait before a stall is forced (>=1).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `aWe`  in  1  pipeline writeback valid.
- `aAddr`  in  `REG_ADDR_LEN`  pipeline destination register.
- `aData`  in  `REG_LENGTH`  pipeline result.
- `bValid`  in  1  long-latency result valid.
- `bReady`  out  1  FIFO can accept a B result.
- `bAddr`  in  `REG_ADDR_LEN`  B destination register.
- `bData`  in  `REG_LENGTH`  B result.
- `stall`  out  1  pipeline must hold writeback; A is not consumed this cycle.
- `we`  out  1  register-file write enable.
- `wAddr`  out  `REG_ADDR_LEN`  register-file write address.
- `wData`  out  `REG_LENGTH`  register-file write data.
- `regaAddr`, `regbAddr`  in  `REG_ADDR_LEN`  register-file read addresses, for forwarding.
- `fwdaValid`, `fwdbValid`  out  1  forwarding hit for read port A / B.
- `fwdaData`, `fwdbData`  out  `REG_LENGTH`  forwarded value.

## Operation
- **State:** FIFO (rd/wr pointers, count 0..DEPTH) and a starvation counter `waitCnt` (0..STARVE_MAX).
- **Enqueue:** on the posedge where `bValid && bReady`. B results with `bAddr==0` are accepted but not stored.
- **`bReady`:** equals `count<DEPTH`. It depends on state only; there is no pop-through when full.
- **Valid A:** `aWe==1 && aAddr!=0`. A writes to r0 are discarded.
- **Priority, evaluated each cycle:**
  - if `stall` is set, the FIFO head issues;
  - else if A is valid, A issues;
  - else if the FIFO is non-empty, the head issues;
  - else `we=0`.
- **Issue:** drives `we=1` with the selected addr/data. Popping the head takes effect at the posedge.
- **`stall`:** equals `(count!=0) && (waitCnt==STARVE_MAX)`. When set, A is ignored and the pipeline re-presents it next cycle.
- **`waitCnt`:**
  - cleared when the FIFO is empty or the head issues;
  - otherwise incremented, saturating at STARVE_MAX.
- **Simultaneous enqueue and pop:** count is unchanged and pointers both advance.
- **Reset (including mid-operation):** FIFO emptied, `waitCnt=0`, all buffered results dropped. While `rst=1`: `we=0`, `bReady=0`, `stall=0`, `fwd*Valid=0`, and all data outputs are 0.

## Timing
- **A:** zero latency. The write-port outputs are combinational from the A inputs, and the register file commits at the same posedge.
- **B:** minimum latency 1 cycle, from accept edge to `we` in the following cycle.
- **Worst-case B latency:** (position in FIFO +1) x (STARVE_MAX+1) cycles.
- **`stall`:** asserted for exactly one cycle per forced drain, then `waitCnt` restarts at 0 for the next head.
- **Throughput:** one write per cycle on the port. B is sustained at 1/cycle only while A is idle.

## Configuration
- **Macro:** `REGFILE_WB_FWD_EN`.
- **Defined:**
  - `fwdaValid=1` when `we && wAddr==regaAddr && regaAddr!=0`, with `fwdaData=wData`; the same rule applies to port b.
  - This closes the same-cycle read/write hazard: the register file read is combinational and returns the old value during the write cycle.
- **Not defined:** `fwd*Valid` and `fwd*Data` are tied to 0, and no compare logic is built.

## Test plan
- **Reset, then idle:** `rst` 1 for 2 cycles -> `we=0`, `bReady=0`, `stall=0`. After `rst` falls: `bReady=1`, `we=0`.
- **A only:** `aWe=1`, `aAddr=5`, `aData=32'h1234` -> same cycle `we=1`, `wAddr=5`, `wData=32'h1234`. With `aAddr=0` -> `we=0`.
- **B queued behind A:**
  - Stimulus: B push (`bAddr=7`, `32'hBEEF`) at cycle 0 while `aWe=1` for cycles 1-3 (STARVE_MAX=4).
  - Response: A wins in cycles 1-3; B writes r7 in cycle 4 when A goes idle.
- **Starvation:**
  - Stimulus: one B entry and `aWe=1` continuously.
  - Response: `stall=1` in the 5th waiting cycle, `we` carries the B entry, and the A data is re-presented and written next cycle.
- **Full and reset:**
  - Stimulus: push 2 B results with A busy.
  - Response: `bReady=0`; a third `bValid` is not accepted. Assert `rst` -> FIFO is empty and both entries are never written.
- **Forwarding (`REGFILE_WB_FWD_EN`):**
  - Stimulus: `aWe=1`, `aAddr=9`, `aData=32'hCAFE`, `regaAddr=9`.
  - Response: `fwdaValid=1`, `fwdaData=32'hCAFE`. Without the macro, `fwdaValid=0`.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Arbiter for the single register-file write port. Merges the
//             in-order pipeline writeback (port A) with results from a
//             long-latency unit (port B). B results are buffered in a small
//             FIFO. When the FIFO head has waited STARVE_MAX cycles, the
//             pipeline is stalled for one cycle so that the head can drain.
//
//  Parameters
//    DEPTH        : B-result FIFO entries (power of two, 2..8)
//    STARVE_MAX   : cycles the FIFO head may wait before a forced drain (>=1)
//    REG_ADDR_LEN : register address width
//    REG_LENGTH   : register data width
//
//  Ports
//    clk, rst            : clock and synchronous active-high reset
//    aWe/aAddr/aData     : pipeline writeback (writes to r0 are discarded)
//    bValid/bReady       : long-latency result handshake
//    bAddr/bData         : long-latency result (r0 results are not stored)
//    stall               : pipeline must hold its writeback this cycle
//    we/wAddr/wData      : register-file write port
//    regaAddr/regbAddr   : register-file read addresses (for forwarding)
//    fwda*/fwdb*         : same-cycle write-to-read forwarding
//
//  Configuration macro
//    REGFILE_WB_FWD_EN   : defined   -> forwarding compare logic is built
//                          undefined -> fwd*Valid / fwd*Data tied to 0
//
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_MAX   = 4,
    parameter int REG_ADDR_LEN = 5,
    parameter int REG_LENGTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // pipeline writeback (port A)
    input  logic                    aWe,
    input  logic [REG_ADDR_LEN-1:0] aAddr,
    input  logic [REG_LENGTH-1:0]   aData,
    // long-latency result (port B)
    input  logic                    bValid,
    output logic                    bReady,
    input  logic [REG_ADDR_LEN-1:0] bAddr,
    input  logic [REG_LENGTH-1:0]   bData,
    // pipeline hold request
    output logic                    stall,
    // register-file write port
    output logic                    we,
    output logic [REG_ADDR_LEN-1:0] wAddr,
    output logic [REG_LENGTH-1:0]   wData,
    // forwarding
    input  logic [REG_ADDR_LEN-1:0] regaAddr,
    input  logic [REG_ADDR_LEN-1:0] regbAddr,
    output logic                    fwdaValid,
    output logic                    fwdbValid,
    output logic [REG_LENGTH-1:0]   fwdaData,
    output logic [REG_LENGTH-1:0]   fwdbData
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_WAIT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(STARVE_MAX);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REG_ADDR_LEN-1:0] r_fifo_addr [DEPTH];
    logic [REG_LENGTH-1:0]   r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_WAIT_W-1:0]     r_wait_cnt;

    // ------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------
    logic w_a_valid;
    logic w_head_valid;
    logic w_stall;
    logic w_head_issue;
    logic w_a_issue;
    logic w_b_ready;
    logic w_push;
    logic w_pop;

    assign w_a_valid    = aWe && (aAddr != '0);
    assign w_head_valid = (r_count != '0);

    // A forced drain only happens when there is a head to drain, so the
    // stall can never fire on an empty FIFO.
    assign w_stall      = !rst && w_head_valid && (r_wait_cnt == c_WAIT_MAX);

    // Head issues on a forced drain, or opportunistically when A is idle.
    assign w_head_issue = !rst && w_head_valid && (w_stall || !w_a_valid);
    assign w_a_issue    = !rst && !w_stall && w_a_valid;

    // bReady looks only at the stored count: a full FIFO does not accept a
    // new result even if the head is popping in the same cycle.
    assign w_b_ready    = !rst && (r_count != c_CNT_FULL);

    // r0 results complete the handshake but are dropped.
    assign w_push       = bValid && w_b_ready && (bAddr != '0);
    assign w_pop        = w_head_issue;

    assign bReady       = w_b_ready;
    assign stall        = w_stall;

    // ------------------------------------------------------------------
    // Write-port mux (combinational from A for zero-latency writeback)
    // ------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        wAddr = '0;
        wData = '0;
        if (w_head_issue) begin
            we    = 1'b1;
            wAddr = r_fifo_addr[r_rd_ptr];
            wData = r_fifo_data[r_rd_ptr];
        end else if (w_a_issue) begin
            we    = 1'b1;
            wAddr = aAddr;
            wData = aData;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            // The counter measures how long the current head has waited; a
            // new head (after a pop, or arriving into an empty FIFO) starts
            // from zero.
            if (!w_head_valid || w_pop) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bAddr;
            r_fifo_data[r_wr_ptr] <= bData;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
`ifdef REGFILE_WB_FWD_EN
    // The register file returns the old value during its write cycle, so
    // the value being written is bypassed to a matching read port. we is
    // already low during reset, which keeps the forwarding outputs at 0.
    logic w_fwda_hit;
    logic w_fwdb_hit;

    assign w_fwda_hit = we && (wAddr == regaAddr) && (regaAddr != '0);
    assign w_fwdb_hit = we && (wAddr == regbAddr) && (regbAddr != '0);

    assign fwdaValid  = w_fwda_hit;
    assign fwdbValid  = w_fwdb_hit;
    assign fwdaData   = w_fwda_hit ? wData : '0;
    assign fwdbData   = w_fwdb_hit ? wData : '0;
`else
    // Read addresses are only needed by the forwarding compare.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{regaAddr, regbAddr};

    assign fwdaValid  = 1'b0;
    assign fwdbValid  = 1'b0;
    assign fwdaData   = '0;
    assign fwdbData   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter (DEPTH=2,
//             STARVE_MAX=4). A table of per-cycle vectors walks through
//             reset, A-only writes, B queued behind A, starvation, full and
//             reset-while-full; a hand-written sequence then fills the FIFO
//             under continuous A traffic and checks both forced drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        aWe;
    logic [4:0]  aAddr;
    logic [31:0] aData;
    logic        bValid;
    logic        bReady;
    logic [4:0]  bAddr;
    logic [31:0] bData;
    logic        stall;
    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [4:0]  regaAddr;
    logic [4:0]  regbAddr;
    logic        fwdaValid;
    logic        fwdbValid;
    logic [31:0] fwdaData;
    logic [31:0] fwdbData;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DEPTH        (2),
        .STARVE_MAX   (4),
        .REG_ADDR_LEN (5),
        .REG_LENGTH   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aWe       (aWe),
        .aAddr     (aAddr),
        .aData     (aData),
        .bValid    (bValid),
        .bReady    (bReady),
        .bAddr     (bAddr),
        .bData     (bData),
        .stall     (stall),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .regaAddr  (regaAddr),
        .regbAddr  (regbAddr),
        .fwdaValid (fwdaValid),
        .fwdbValid (fwdbValid),
        .fwdaData  (fwdaData),
        .fwdbData  (fwdbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        aWe;
        logic [4:0]  aAddr;
        logic [31:0] aData;
        logic        bValid;
        logic [4:0]  bAddr;
        logic [31:0] bData;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic        eStall;
        logic        eReady;
        logic        eFa;     // forwarding hit on port a when forwarding is built
        logic        eFb;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic r, input logic aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
        input logic es, input logic er, input logic efa, input logic efb);
        vec_t v;
        v.rst = r;  v.aWe = aw; v.aAddr = aa; v.aData = ad;
        v.bValid = bv; v.bAddr = ba; v.bData = bd; v.ra = ra; v.rb = rb;
        v.eWe = ewe; v.eAddr = ea; v.eData = ed; v.eStall = es; v.eReady = er;
        v.eFa = efa; v.eFb = efb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic aw, input logic [4:0] aa,
                         input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                         input logic [31:0] bd, input logic [4:0] ra, input logic [4:0] rb);
        rst = r; aWe = aw; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd; regaAddr = ra; regbAddr = rb;
    endtask

    initial begin
        logic        efa;
        logic        efb;
        logic [31:0] a_data;
        logic        exp_stall;
        logic        exp_ready;
        logic [4:0]  exp_b_addr;
        logic [31:0] exp_b_data;

        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        //             rst aWe aAddr aData        bV  bAddr bData        ra     rb    | we  wAddr  wData        stall rdy  fa    fb
        // reset held two cycles with live inputs: everything stays 0
        vecs[0]  = mk(1'b1,1'b1,5'd5, 32'h1111, 1'b1,5'd3, 32'h3333, 5'd5, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b0,1'b0,1'b0);
        vecs[1]  = mk(1'b1,1'b0,5'd0, 32'h0,    1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b0,1'b0,1'b0);
        vecs[2]  = mk(1'b0,1'b0,5'd0, 32'h0,    1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);
        // A only, then A to r0
        vecs[3]  = mk(1'b0,1'b1,5'd5, 32'h1234, 1'b0,5'd0, 32'h0,    5'd5, 5'd5, 1'b1,5'd5, 32'h1234,  1'b0,1'b1,1'b1,1'b1);
        vecs[4]  = mk(1'b0,1'b1,5'd0, 32'h5555, 1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);
        // B pushed, A busy three cycles, B drains when A goes idle
        vecs[5]  = mk(1'b0,1'b0,5'd0, 32'h0,    1'b1,5'd7, 32'hBEEF, 5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);
        vecs[6]  = mk(1'b0,1'b1,5'd1, 32'hA1,   1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd1, 32'hA1,    1'b0,1'b1,1'b0,1'b0);
        vecs[7]  = mk(1'b0,1'b1,5'd2, 32'hA2,   1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd2, 32'hA2,    1'b0,1'b1,1'b0,1'b0);
        vecs[8]  = mk(1'b0,1'b1,5'd3, 32'hA3,   1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd3, 32'hA3,    1'b0,1'b1,1'b0,1'b0);
        vecs[9]  = mk(1'b0,1'b0,5'd0, 32'h0,    1'b0,5'd0, 32'h0,    5'd0, 5'd7, 1'b1,5'd7, 32'hBEEF,  1'b0,1'b1,1'b0,1'b1);
        vecs[10] = mk(1'b0,1'b0,5'd0, 32'h0,    1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);
        // starvation: one B entry, A busy; stall in the 5th waiting cycle
        vecs[11] = mk(1'b0,1'b1,5'd4, 32'hA40,  1'b1,5'd8, 32'hB8,   5'd0, 5'd0, 1'b1,5'd4, 32'hA40,   1'b0,1'b1,1'b0,1'b0);
        vecs[12] = mk(1'b0,1'b1,5'd4, 32'hA41,  1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd4, 32'hA41,   1'b0,1'b1,1'b0,1'b0);
        vecs[13] = mk(1'b0,1'b1,5'd4, 32'hA42,  1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd4, 32'hA42,   1'b0,1'b1,1'b0,1'b0);
        vecs[14] = mk(1'b0,1'b1,5'd4, 32'hA43,  1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd4, 32'hA43,   1'b0,1'b1,1'b0,1'b0);
        vecs[15] = mk(1'b0,1'b1,5'd4, 32'hA44,  1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b1,5'd4, 32'hA44,   1'b0,1'b1,1'b0,1'b0);
        vecs[16] = mk(1'b0,1'b1,5'd4, 32'hA45,  1'b0,5'd0, 32'h0,    5'd4, 5'd8, 1'b1,5'd8, 32'hB8,    1'b1,1'b1,1'b0,1'b1);
        vecs[17] = mk(1'b0,1'b1,5'd4, 32'hA45,  1'b0,5'd0, 32'h0,    5'd4, 5'd0, 1'b1,5'd4, 32'hA45,   1'b0,1'b1,1'b1,1'b0);
        // fill with A busy, third push refused, then reset drops both
        vecs[18] = mk(1'b0,1'b1,5'd6, 32'hC1,   1'b1,5'd10,32'hD1,   5'd0, 5'd0, 1'b1,5'd6, 32'hC1,    1'b0,1'b1,1'b0,1'b0);
        vecs[19] = mk(1'b0,1'b1,5'd6, 32'hC2,   1'b1,5'd11,32'hD2,   5'd0, 5'd0, 1'b1,5'd6, 32'hC2,    1'b0,1'b1,1'b0,1'b0);
        vecs[20] = mk(1'b0,1'b1,5'd6, 32'hC3,   1'b1,5'd12,32'hD3,   5'd0, 5'd0, 1'b1,5'd6, 32'hC3,    1'b0,1'b0,1'b0,1'b0);
        vecs[21] = mk(1'b1,1'b1,5'd6, 32'hC4,   1'b1,5'd12,32'hD3,   5'd6, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b0,1'b0,1'b0);
        // after reset nothing drains; a B result to r0 is accepted, never written
        vecs[22] = mk(1'b0,1'b0,5'd0, 32'h0,    1'b1,5'd0, 32'hEE,   5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);
        vecs[23] = mk(1'b0,1'b0,5'd0, 32'h0,    1'b0,5'd0, 32'h0,    5'd0, 5'd0, 1'b0,5'd0, 32'h0,     1'b0,1'b1,1'b0,1'b0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].aWe, vecs[i].aAddr, vecs[i].aData,
                  vecs[i].bValid, vecs[i].bAddr, vecs[i].bData, vecs[i].ra, vecs[i].rb);
            #1;
`ifdef REGFILE_WB_FWD_EN
            efa = vecs[i].eFa;
            efb = vecs[i].eFb;
`else
            efa = 1'b0;
            efb = 1'b0;
`endif
            chk($sformatf("row%0d_we", i),     32'(we),        32'(vecs[i].eWe));
            chk($sformatf("row%0d_waddr", i),  32'(wAddr),     32'(vecs[i].eAddr));
            chk($sformatf("row%0d_wdata", i),  wData,          vecs[i].eData);
            chk($sformatf("row%0d_stall", i),  32'(stall),     32'(vecs[i].eStall));
            chk($sformatf("row%0d_bready", i), 32'(bReady),    32'(vecs[i].eReady));
            chk($sformatf("row%0d_fwda", i),   32'(fwdaValid), 32'(efa));
            chk($sformatf("row%0d_fwdad", i),  fwdaData,       efa ? vecs[i].eData : 32'h0);
            chk($sformatf("row%0d_fwdb", i),   32'(fwdbValid), 32'(efb));
            chk($sformatf("row%0d_fwdbd", i),  fwdbData,       efb ? vecs[i].eData : 32'h0);
        end

        // Fill the FIFO (r13 then r14) under continuous A traffic. The heads
        // must drain in order via one-cycle forced stalls, 3 and 8 cycles
        // into the loop; a stalled A is re-presented and written afterwards.
        a_data = 32'hA000;
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd20, a_data, 1'b1, 5'd13, 32'hD13, 5'd0, 5'd0);
        #1;
        chk("fill0_waddr", 32'(wAddr), 32'd20);
        chk("fill0_wdata", wData, a_data);
        a_data = a_data + 1;
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd20, a_data, 1'b1, 5'd14, 32'hD14, 5'd0, 5'd0);
        #1;
        chk("fill1_bready", 32'(bReady), 32'd1);
        chk("fill1_wdata", wData, a_data);
        a_data = a_data + 1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'd20, a_data, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            #1;
            exp_stall  = (c == 3) || (c == 8);
            exp_ready  = (c >= 4);
            exp_b_addr = (c == 3) ? 5'd13 : 5'd14;
            exp_b_data = (c == 3) ? 32'hD13 : 32'hD14;
            chk($sformatf("drain%0d_stall", c),  32'(stall),  32'(exp_stall));
            chk($sformatf("drain%0d_bready", c), 32'(bReady), 32'(exp_ready));
            chk($sformatf("drain%0d_we", c),     32'(we),     32'd1);
            if (exp_stall) begin
                chk($sformatf("drain%0d_waddr", c), 32'(wAddr), 32'(exp_b_addr));
                chk($sformatf("drain%0d_wdata", c), wData,      exp_b_data);
            end else begin
                chk($sformatf("drain%0d_waddr", c), 32'(wAddr), 32'd20);
                chk($sformatf("drain%0d_wdata", c), wData,      a_data);
                a_data = a_data + 1;
            end
        end

        // FIFO drained: idle A leaves the port quiet
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("final_we", 32'(we), 32'd0);
        chk("final_bready", 32'(bReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
